// File: rtl/ksa_pkg.sv
// Shared constants, state encoding and key-byte selection for the RC4 key-scheduling stage.
// The init and PRGA stages import the same S-memory geometry from here.
package ksa_pkg;

    localparam int KEYLEN  = 3;
    localparam int ADDR_W  = 8;
    localparam int S_DEPTH = 2 ** ADDR_W;
    localparam int KIDX_W  = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_I  = 3'd1,
        LAT_I = 3'd2,
        RD_J  = 3'd3,
        LAT_J = 3'd4,
        WR_I  = 3'd5,
        WR_J  = 3'd6,
        DONE  = 3'd7
    } ksa_state_e;

    // Key byte 0 is the most significant byte of the packed key.
    function automatic logic [7:0] key_byte(input logic [8*KEYLEN-1:0] key,
                                            input logic [KIDX_W-1:0]   k);
        return key[8*(KEYLEN-1-int'(k)) +: 8];
    endfunction

endpackage

// File: rtl/ksa.sv
// RC4 key scheduler: permutes an identity S array in place using the secret key.
// One iteration is read S[i], read S[j], write S[i], write S[j]; all memory outputs are registered.
module ksa
    import ksa_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                finish,
    input  logic [8*KEYLEN-1:0] key,
    output logic [ADDR_W-1:0]   address,
    output logic [7:0]          data,
    output logic                wren,
    input  logic [7:0]          q,
    output ksa_state_e          dbg_state
);

    ksa_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic [7:0]          si_q, si_d;
    logic [7:0]          sj_q, sj_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                wren_q, wren_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
        end
    end

    // Memory outputs are loaded on the transition into the state that presents them,
    // so address/data/wren are valid for the whole cycle of RD_*/WR_* states.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        si_d    = si_q;
        sj_d    = sj_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = i_q;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                state_d = LAT_I;
            end
            LAT_I: begin
                si_d    = q;
                j_d     = j_q + q + key_byte(key, kidx_q);
                addr_d  = j_d;
                state_d = RD_J;
            end
            RD_J: begin
                state_d = LAT_J;
            end
            LAT_J: begin
                sj_d    = q;
                addr_d  = i_q;
                data_d  = q;
                wren_d  = 1'b1;
                state_d = WR_I;
            end
            WR_I: begin
                addr_d  = j_q;
                data_d  = si_q;
                wren_d  = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                if (i_q == ADDR_W'(S_DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    kidx_d  = (kidx_q == KIDX_W'(KEYLEN - 1)) ? '0 : kidx_q + 1'b1;
                    addr_d  = i_d;
                    state_d = RD_I;
                end
            end
            DONE: begin
                if (!start) begin
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign finish    = (state_q == DONE);
    assign address   = addr_q;
    assign data      = data_q;
    assign wren      = wren_q;
    assign dbg_state = state_q;

endmodule
